hd_program_loader: RTL
======================

HD_PROGRAM_LOADER -- requirements
Module: hd_program_loader

Interface
REQ-001 SHALL have: clock  input  1  system clock (divided processor clock); all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  load request, sampled only in IDLE.
REQ-004 SHALL have: abort  input  1  cancel load in progress.
REQ-005 SHALL have: src_track  input  10  first HD track.
REQ-006 SHALL have: src_sector  input  4  first HD sector.
REQ-007 SHALL have: word_count  input  12  words to copy; 0 = empty load.
REQ-008 SHALL have: dst_base  input  12  first instruction-memory write address.
REQ-009 SHALL have: hd_data  input  32  HD read data, valid the cycle after hd_read_en.
REQ-010 SHALL have: hd_track  output  10; hd_sector  output  4; hd_read_en  output  1  HD read port.
REQ-011 SHALL have: mi_we  output  1; mi_addr  output  12; mi_data  output  32  instruction-memory write port.
REQ-012 SHALL have: busy  output  1; done  output  1 (one-cycle pulse); words_loaded  output  12.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE; outputs decoded from registered state (Moore).
REQ-014 IDLE: start=1 at an edge SHALL latch src_track, src_sector, word_count, dst_base, clear index and words_loaded, go READ; if word_count=0 go DONE instead.
REQ-015 READ: hd_read_en=1, hd_track/hd_sector = current pointer; next edge go WRITE.
REQ-016 WRITE: mi_we=1, mi_addr = (dst_base + index) mod 4096, mi_data = hd_data; at edge increment index, words_loaded, advance pointer.
REQ-017 Pointer advance: sector+1; sector 15 wraps to 0 with track+1; track 1023 wraps to 0.
REQ-018 WRITE edge: if index+1 = word_count go DONE, else go READ; throughput 2 cycles/word.
REQ-019 DONE: done=1 for exactly one cycle, busy=0; next edge go IDLE.
REQ-020 busy SHALL be 1 in READ and WRITE only; 0 in IDLE and DONE.
REQ-021 Latency: start edge to done cycle = 2*word_count + 1 cycles (1 cycle for word_count=0).
REQ-022 start outside IDLE SHALL be ignored; latched parameters SHALL not change mid-load.
REQ-023 abort=1 in READ or WRITE SHALL force mi_we=0 that cycle and go IDLE next edge, no done pulse; words_loaded holds completed count.
REQ-024 abort in IDLE or DONE SHALL have no effect; abort and start together in IDLE: start wins.
REQ-025 words_loaded SHALL hold its value after DONE until next accepted start.
REQ-026 hd_read_en, mi_we SHALL be 0 and hd_track, hd_sector, mi_addr, mi_data SHALL be 0 outside READ/WRITE respectively.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, clear index, words_loaded, latched parameters; busy=done=mi_we=hd_read_en=0; overrides start, abort and any in-progress load.
REQ-028 Reset mid-load SHALL suppress mi_we from the cycle after the reset edge onward; no done pulse.

Verification
REQ-029 start, track=5, sector=2, count=3, base=0x100 -> reads (5,2),(5,3),(5,4); writes 0x100..0x102 with hd_data; done 7 cycles after start edge; words_loaded=3.
REQ-030 sector=14, track=1023, count=4 -> reads (1023,14),(1023,15),(0,0),(0,1).
REQ-031 base=0xFFE, count=3 -> mi_addr 0xFFE, 0xFFF, 0x000.
REQ-032 count=0 -> done pulse in the cycle after start edge, no hd_read_en, no mi_we, busy never 1.
REQ-033 count=5, abort during 3rd WRITE -> no write that cycle, no done, words_loaded=2, IDLE next cycle; new start accepted afterwards.
REQ-034 reset during READ of word 2, start held high throughout -> IDLE after reset edge, outputs 0; load restarts from word 0 only after reset deasserts.

Source files
------------

// File: rtl/hd_program_loader_if.sv
// Control, hard-disk read and instruction-memory write signals of the program loader.
// The loader takes the slave modport; whoever drives the load takes the master modport.
interface hd_program_loader_if;
    logic        start;
    logic        abort;
    logic [9:0]  src_track;
    logic [3:0]  src_sector;
    logic [11:0] word_count;
    logic [11:0] dst_base;
    logic [31:0] hd_data;
    logic [9:0]  hd_track;
    logic [3:0]  hd_sector;
    logic        hd_read_en;
    logic        mi_we;
    logic [11:0] mi_addr;
    logic [31:0] mi_data;
    logic        busy;
    logic        done;
    logic [11:0] words_loaded;

    modport master (
        output start, abort, src_track, src_sector, word_count, dst_base, hd_data,
        input  hd_track, hd_sector, hd_read_en, mi_we, mi_addr, mi_data, busy, done,
               words_loaded
    );

    modport slave (
        input  start, abort, src_track, src_sector, word_count, dst_base, hd_data,
        output hd_track, hd_sector, hd_read_en, mi_we, mi_addr, mi_data, busy, done,
               words_loaded
    );
endinterface

// File: rtl/hd_program_loader.sv
// Copies word_count words from the hard disk into instruction memory, one word per
// READ/WRITE pair. Outputs are decoded from the registered state only, except that abort
// masks the write strobe in the same cycle and mi_data passes the disk word straight through.
module hd_program_loader (
    input  logic                  clock,
    input  logic                  reset,
    hd_program_loader_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e      state_q;
    logic [9:0]  track_q;
    logic [3:0]  sector_q;
    logic [11:0] count_q;
    logic [11:0] base_q;
    // Completed-word count; it is also the index of the word currently in flight.
    logic [11:0] loaded_q;

    // Sequencer: latch the request, step through the words, return to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            track_q  <= '0;
            sector_q <= '0;
            count_q  <= '0;
            base_q   <= '0;
            loaded_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        track_q  <= bus.src_track;
                        sector_q <= bus.src_sector;
                        count_q  <= bus.word_count;
                        base_q   <= bus.dst_base;
                        loaded_q <= '0;
                        state_q  <= (bus.word_count == 12'd0) ? StDone : StRead;
                    end
                end
                StRead: begin
                    state_q <= bus.abort ? StIdle : StWrite;
                end
                StWrite: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                    end else begin
                        loaded_q <= loaded_q + 12'd1;
                        // Track and sector form one linear disk address, so a plain
                        // increment gives both the sector wrap and the track wrap.
                        {track_q, sector_q} <= {track_q, sector_q} + 14'd1;
                        state_q <= (loaded_q + 12'd1 == count_q) ? StDone : StRead;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Port decode from the registered state; idle ports are held at zero.
    always_comb begin
        bus.hd_read_en   = 1'b0;
        bus.hd_track     = '0;
        bus.hd_sector    = '0;
        bus.mi_we        = 1'b0;
        bus.mi_addr      = '0;
        bus.mi_data      = '0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        bus.words_loaded = loaded_q;
        case (state_q)
            StRead: begin
                bus.busy       = 1'b1;
                bus.hd_read_en = 1'b1;
                bus.hd_track   = track_q;
                bus.hd_sector  = sector_q;
            end
            StWrite: begin
                bus.busy    = 1'b1;
                bus.mi_we   = ~bus.abort;
                bus.mi_addr = base_q + loaded_q;
                bus.mi_data = bus.hd_data;
            end
            StDone: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule
